membrane_reg_bank: RTL and testbench

MEMBRANE_REG_BANK -- requirements
Module: membrane_reg_bank

---
 rtl/membrane_reg_bank.sv | 74 +++++++
 tb/tb_membrane_reg_bank.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/membrane_reg_bank.sv
// Per-channel neuron membrane state registers.
// Each channel supports saturating loads, spike reset, and a refractory hold.
module membrane_reg_bank #(
   parameter int             N       = 4,
   parameter int             W       = 21,
   parameter logic [W-1:0]   V_RESET = 21'h1FE598,
   parameter int             REFRAC  = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*(W+2)-1:0] d,
   input  logic [N-1:0]       we,
   input  logic [N-1:0]       set,
   output logic [N*W-1:0]     q,
   output logic [N-1:0]       refrac,
   output logic [N-1:0]       sat
);

   localparam logic [7:0] RC = 8'(REFRAC);
   localparam logic [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};

   for (genvar k = 0; k < N; k++) begin : g_ch
      logic [W+1:0] dk;
      logic [W-1:0] qk;
      logic [W-1:0] clamped;
      logic [7:0]   cnt;
      logic         ovf;
      logic         sat_k;
      logic         ref_k;

      assign dk = d[k*(W+2) +: W+2];

      // In range exactly when the top three bits are a pure sign extension.
      always_comb begin
         ovf = (dk[W+1:W-1] != 3'b000) && (dk[W+1:W-1] != 3'b111);
         if (!ovf)
            clamped = dk[W-1:0];
         else if (dk[W+1])
            clamped = Q_MIN;
         else
            clamped = Q_MAX;
      end

      // ref_k mirrors (cnt != 0) in its own flop, tracking cnt's next value.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            qk    <= V_RESET;
            cnt   <= '0;
            sat_k <= 1'b0;
            ref_k <= 1'b0;
         end else if (set[k]) begin
            qk    <= V_RESET;
            cnt   <= RC;
            sat_k <= 1'b0;
            ref_k <= (RC != 8'd0);
         end else if (cnt != 8'd0) begin
            cnt   <= cnt - 8'd1;
            sat_k <= 1'b0;
            ref_k <= (cnt != 8'd1);
         end else if (we[k]) begin
            qk    <= clamped;
            sat_k <= ovf;
         end else begin
            sat_k <= 1'b0;
         end
      end

      assign q[k*W +: W] = qk;
      assign refrac[k]   = ref_k;
      assign sat[k]      = sat_k;
   end

endmodule

// File: tb/tb_membrane_reg_bank.sv
// Bench for membrane_reg_bank: directed table, corner sequences,
// and random traffic against a per-edge behavioural model.
module tb_membrane_reg_bank;

   localparam int N  = 4;
   localparam int W  = 21;
   localparam int DW = W + 2;
   localparam int RF = 3;
   localparam int VR = -6760;
   localparam int QMAX = (1 << (W-1)) - 1;
   localparam int QMIN = -(1 << (W-1));

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*DW-1:0] d;
   logic [N-1:0]    we;
   logic [N-1:0]    set;
   logic [N*W-1:0]  q;
   logic [N-1:0]    refrac;
   logic [N-1:0]    sat;

   int n_chk  = 0;
   int n_fail = 0;

   int mq   [N];
   int mlast[N];
   bit msat [N];
   int edge_no;

   always #5 clk = ~clk;

   membrane_reg_bank dut (
      .clk(clk), .rst_n(rst_n), .d(d), .we(we),
      .set(set), .q(q), .refrac(refrac), .sat(sat)
   );

   typedef struct {
      logic [3:0] we;
      logic [3:0] set;
      int         dv;
      int         ch;
      int         eq;
      logic       er;
      logic       es;
   } vec_t;

   vec_t vt[17];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int qch(input int k);
      logic [W-1:0] v;
      v = q[k*W +: W];
      return int'($signed(v));
   endfunction

   function automatic int clampv(input int v);
      if (v > QMAX) return QMAX;
      if (v < QMIN) return QMIN;
      return v;
   endfunction

   function automatic bit m_ref(input int k);
      return edge_no < mlast[k] + RF;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         mq[k]    = VR;
         mlast[k] = -1000;
         msat[k]  = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("%s q%0d", tag, k), qch(k), mq[k]);
         chk($sformatf("%s refrac%0d", tag, k), int'(refrac[k]), int'(m_ref(k)));
         chk($sformatf("%s sat%0d", tag, k), int'(sat[k]), int'(msat[k]));
      end
   endtask

   // Drive after a negedge, clock once, update model, check at next negedge.
   task automatic step(input logic [3:0] w, input logic [3:0] s,
                       input int dv[N], input string tag);
      logic [DW-1:0] dd;
      for (int k = 0; k < N; k++) begin
         dd = DW'(dv[k]);
         d[k*DW +: DW] = dd;
      end
      we  = w;
      set = s;
      @(posedge clk);
      edge_no++;
      for (int k = 0; k < N; k++) begin
         if (s[k]) begin
            mq[k] = VR; mlast[k] = edge_no; msat[k] = 1'b0;
         end else if (edge_no <= mlast[k] + RF) begin
            msat[k] = 1'b0;
         end else if (w[k]) begin
            mq[k] = clampv(dv[k]);
            msat[k] = (mq[k] != dv[k]);
         end else begin
            msat[k] = 1'b0;
         end
      end
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic step1(input logic [3:0] w, input logic [3:0] s,
                        input int v, input string tag);
      int dv[N];
      for (int k = 0; k < N; k++) dv[k] = v;
      step(w, s, dv, tag);
   endtask

   initial begin
      int dv[N];
      vt[0]  = '{4'b0001, 4'b0000, 1000,     0, 1000,  1'b0, 1'b0};
      vt[1]  = '{4'b0010, 4'b0000, 2000000,  1, QMAX,  1'b0, 1'b1};
      vt[2]  = '{4'b0010, 4'b0000, -2000000, 1, QMIN,  1'b0, 1'b1};
      vt[3]  = '{4'b0010, 4'b0000, 5,        1, 5,     1'b0, 1'b0};
      vt[4]  = '{4'b0100, 4'b0100, 77,       2, VR,    1'b1, 1'b0};
      vt[5]  = '{4'b0100, 4'b0000, 77,       2, VR,    1'b1, 1'b0};
      vt[6]  = '{4'b0100, 4'b0000, 77,       2, VR,    1'b1, 1'b0};
      vt[7]  = '{4'b0100, 4'b0000, 77,       2, VR,    1'b0, 1'b0};
      vt[8]  = '{4'b0100, 4'b0000, 77,       2, 77,    1'b0, 1'b0};
      vt[9]  = '{4'b0010, 4'b0001, -42,      0, VR,    1'b1, 1'b0};
      vt[10] = '{4'b0000, 4'b0000, 0,        1, -42,   1'b0, 1'b0};
      vt[11] = '{4'b0010, 4'b0000, QMAX,     1, QMAX,  1'b0, 1'b0};
      vt[12] = '{4'b0010, 4'b0000, QMAX+1,   1, QMAX,  1'b0, 1'b1};
      vt[13] = '{4'b0010, 4'b0000, QMIN,     1, QMIN,  1'b0, 1'b0};
      vt[14] = '{4'b0010, 4'b0000, QMIN-1,   1, QMIN,  1'b0, 1'b1};
      vt[15] = '{4'b0000, 4'b0000, 9,        1, QMIN,  1'b0, 1'b0};
      vt[16] = '{4'b0001, 4'b0000, 9,        3, VR,    1'b0, 1'b0};

      rst_n = 1'b0; we = '0; set = '0; d = '0;
      edge_no = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;

      foreach (vt[i]) begin
         step1(vt[i].we, vt[i].set, vt[i].dv, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d q", i), qch(vt[i].ch), vt[i].eq);
         chk($sformatf("vec%0d refrac", i), int'(refrac[vt[i].ch]), int'(vt[i].er));
         chk($sformatf("vec%0d sat", i), int'(sat[vt[i].ch]), int'(vt[i].es));
      end

      // Re-trigger on channel 3: set at t and t+2, we held afterwards.
      step1(4'b0000, 4'b1000, 0, "rt t");
      step1(4'b1000, 4'b0000, 123, "rt t+1");
      step1(4'b1000, 4'b1000, 123, "rt t+2");
      step1(4'b1000, 4'b0000, 123, "rt t+3");
      chk("rt t+3 refrac3", int'(refrac[3]), 1);
      step1(4'b1000, 4'b0000, 123, "rt t+4");
      chk("rt t+4 refrac3", int'(refrac[3]), 1);
      step1(4'b1000, 4'b0000, 123, "rt t+5");
      chk("rt t+5 q3", qch(3), VR);
      chk("rt t+5 refrac3", int'(refrac[3]), 0);
      step1(4'b1000, 4'b0000, 123, "rt t+6");
      chk("rt t+6 q3", qch(3), 123);

      // Async reset mid-refractory with channel 0 holding a loaded value.
      step1(4'b0001, 4'b0000, 1000, "pre-rst load");
      step1(4'b0000, 4'b0010, 0, "pre-rst set");
      chk("pre-rst refrac1", int'(refrac[1]), 1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async q0", qch(0), VR);
      chk("async refrac1", int'(refrac[1]), 0);
      check_all("async");
      @(negedge clk);
      rst_n = 1'b1;
      step1(4'b0010, 4'b0000, 555, "post-rst load");
      chk("post-rst q1", qch(1), 555);

      for (int i = 0; i < 400; i++) begin
         logic [3:0] w, s;
         for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 3))
               0: dv[k] = $urandom_range(0, 4000) + QMAX - 2000;
               1: dv[k] = QMIN - 2000 + $urandom_range(0, 4000);
               default: dv[k] = $urandom_range(0, (1 << DW) - 1) - (1 << (DW-1));
            endcase
            s[k] = ($urandom_range(0, 7) == 0);
         end
         w = 4'($urandom);
         step(w, s, dv, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
